// File: rtl/parser_rule_loader_pkg.sv
// Shared types and helpers for the parser rule loader.
// Holds the rule-region and error encodings, the loader FSM states,
// the parser conf address-map field positions and the address encoder.
package parser_rule_loader_pkg;

  // Field positions inside the 32-bit parser conf address.
  localparam int ADDR_IDX_LSB   = 0;
  localparam int ADDR_IDX_W     = 6;
  localparam int ADDR_SEL_LSB   = 8;
  localparam int ADDR_SEL_W     = 3;
  localparam int ADDR_LAYER_LSB = 12;
  localparam int ADDR_LAYER_W   = 4;

  // Rule region selected by the sel field.
  typedef enum logic [ADDR_SEL_W-1:0] {
    RULE        = 3'd0,
    TYPE_DATA   = 3'd1,
    TYPE_OFFSET = 3'd2,
    KEY_OFFSET  = 3'd3,
    HEAD_SHIFT  = 3'd4,
    META_SHIFT  = 3'd5
  } rule_sel_e;

  // Host command as captured at accept. sel is kept raw so that the
  // out-of-range codes 6 and 7 can still be seen and rejected.
  typedef struct packed {
    logic [ADDR_LAYER_W-1:0] layer;
    logic [ADDR_SEL_W-1:0]   sel;
    logic [ADDR_IDX_W-1:0]   idx;
    logic [31:0]             wdata;
  } rule_cmd_t;

  // Sticky error code reported to the host.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILLEGAL  = 2'd1,
    ERR_MISMATCH = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } loader_err_e;

  // Loader FSM states. READ and WAIT are only reachable in verify builds.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    WAIT  = 3'd4
  } loader_state_e;

  // Build the conf address {16'b0, layer, 1'b0, sel, 2'b0, idx}.
  function automatic logic [31:0] rule_addr_enc(
    input logic [ADDR_LAYER_W-1:0] layer,
    input logic [ADDR_SEL_W-1:0]   sel,
    input logic [ADDR_IDX_W-1:0]   idx
  );
    logic [31:0] addr;
    addr = '0;
    addr[ADDR_LAYER_LSB +: ADDR_LAYER_W] = layer;
    addr[ADDR_SEL_LSB   +: ADDR_SEL_W]   = sel;
    addr[ADDR_IDX_LSB   +: ADDR_IDX_W]   = idx;
    return addr;
  endfunction

endpackage

// File: rtl/parser_rule_loader_if.sv
// Host command stream, parser rule bus and status signals of the loader.
// The master modport is the loader's view; slave is the host/parser side.
interface parser_rule_loader_if #(
  parameter int LAYER_W = 4
);
  // Host command stream.
  logic               cmd_valid;
  logic               cmd_ready;
  logic [LAYER_W-1:0] cmd_layer;
  logic [2:0]         cmd_sel;
  logic [5:0]         cmd_idx;
  logic [31:0]        cmd_wdata;
  // Parser rule write/read bus.
  logic               rule_wren;
  logic               rule_rden;
  logic [31:0]        rule_addr;
  logic [31:0]        rule_wdata;
  logic               rule_rdata_valid;
  logic [31:0]        rule_rdata;
  // Status towards the host.
  logic               busy;
  logic [15:0]        wr_cnt;
  logic [1:0]         err;
  logic [31:0]        err_addr;
  logic               err_clr;

  modport master (
    input  cmd_valid, cmd_layer, cmd_sel, cmd_idx, cmd_wdata,
    input  rule_rdata_valid, rule_rdata, err_clr,
    output cmd_ready, rule_wren, rule_rden, rule_addr, rule_wdata,
    output busy, wr_cnt, err, err_addr
  );

  modport slave (
    output cmd_valid, cmd_layer, cmd_sel, cmd_idx, cmd_wdata,
    output rule_rdata_valid, rule_rdata, err_clr,
    input  cmd_ready, rule_wren, rule_rden, rule_addr, rule_wdata,
    input  busy, wr_cnt, err, err_addr
  );

endinterface

// File: rtl/parser_rule_loader.sv
// Configuration master for the pipelined parser rule tables.
// Takes one host command at a time, checks it against the rule address
// map, issues a single-cycle write strobe and keeps a sticky error latch
// plus a write counter for the host.
// Optional readback check: define PARSER_RULE_VERIFY_EN to read back every
// non-RULE write and flag data mismatches or a missing response.
module parser_rule_loader
  import parser_rule_loader_pkg::*;
#(
  parameter int LAYER_W    = 4,
  parameter int KEY_NUM    = 8,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  parser_rule_loader_if.master bus
);

  // One counter serves both the gap and the readback timeout.
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);
  localparam loader_state_e POST_WRITE = (GAP_CYCLES > 0) ? GAP : IDLE;

  loader_state_e      state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q, wdata_q;
  logic [15:0]        wr_cnt_q;
  loader_err_e        err_q;
  logic [31:0]        err_addr_q;

  logic [LAYER_W-1:0] cmd_layer;
  rule_cmd_t          cmd_in;
  logic [31:0]        cmd_addr;
  logic               cmd_legal;
  logic               accept;
  logic               new_err;
  loader_err_e        new_code;
  logic [31:0]        new_addr;

  // Region/index legality against the parser conf map.
  function automatic logic rule_legal(input logic [2:0] sel, input logic [5:0] idx);
    case (sel)
      RULE, HEAD_SHIFT, META_SHIFT: return idx == '0;
      TYPE_DATA, TYPE_OFFSET:       return idx < 6'd16;
      KEY_OFFSET:                   return int'(idx) < KEY_NUM;
      default:                      return 1'b0;
    endcase
  endfunction

  assign cmd_layer = bus.cmd_layer;
  assign cmd_in    = '{layer: ADDR_LAYER_W'(cmd_layer), sel: bus.cmd_sel,
                       idx: bus.cmd_idx, wdata: bus.cmd_wdata};
  assign cmd_addr  = rule_addr_enc(cmd_in.layer, cmd_in.sel, cmd_in.idx);
  assign cmd_legal = rule_legal(cmd_in.sel, cmd_in.idx);

  // Ready is also gated by reset so every output reads 0 while in reset.
  assign bus.cmd_ready = (state == IDLE) && !i_rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and error detection.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    new_err   = 1'b0;
    new_code  = ERR_NONE;
    new_addr  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_legal) begin
            state_nxt = WRITE;
          end else begin
            new_err  = 1'b1;
            new_code = ERR_ILLEGAL;
            new_addr = cmd_addr;
          end
        end
      end
      WRITE: begin
        state_nxt = POST_WRITE;
`ifdef PARSER_RULE_VERIFY_EN
        if (addr_q[ADDR_SEL_LSB +: ADDR_SEL_W] != RULE) state_nxt = READ;
`endif
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) state_nxt = IDLE;
      end
`ifdef PARSER_RULE_VERIFY_EN
      READ: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.rule_rdata_valid) begin
          state_nxt = POST_WRITE;
          if (bus.rule_rdata != wdata_q) begin
            new_err  = 1'b1;
            new_code = ERR_MISMATCH;
            new_addr = addr_q;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt = POST_WRITE;
          new_err   = 1'b1;
          new_code  = ERR_TIMEOUT;
          new_addr  = addr_q;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Cycles spent in the current GAP or WAIT state; cleared on every transition.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                            cnt <= '0;
    else if (state_nxt != state)          cnt <= '0;
    else if (state == GAP || state == WAIT) cnt <= cnt + CNT_W'(1);
  end

  // Capture address and data of a legal command; held until the next one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept && cmd_legal) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_in.wdata;
    end
  end

  // Count issued writes; wraps naturally at 16 bits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               wr_cnt_q <= '0;
    else if (state == WRITE) wr_cnt_q <= wr_cnt_q + 16'd1;
  end

  // Sticky first-error latch; a clear in the same cycle as a new error
  // still lets the new error in.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q      <= ERR_NONE;
      err_addr_q <= '0;
    end else if (new_err && (err_q == ERR_NONE || bus.err_clr)) begin
      err_q      <= new_code;
      err_addr_q <= new_addr;
    end else if (bus.err_clr) begin
      err_q      <= ERR_NONE;
      err_addr_q <= '0;
    end
  end

  assign bus.rule_wren  = (state == WRITE);
  assign bus.rule_addr  = addr_q;
  assign bus.rule_wdata = wdata_q;
  assign bus.busy       = (state != IDLE);
  assign bus.wr_cnt     = wr_cnt_q;
  assign bus.err        = err_q;
  assign bus.err_addr   = err_addr_q;

`ifdef PARSER_RULE_VERIFY_EN
  assign bus.rule_rden = (state == READ);
`else
  // Readback path is absent; the response inputs are intentionally ignored.
  logic unused_rdata;
  assign unused_rdata  = ^{bus.rule_rdata_valid, bus.rule_rdata};
  assign bus.rule_rden = 1'b0;
`endif

endmodule

// File: doc/parser_rule_loader.md
Name: parser_rule_loader

Overview:
- Configuration master for the pipelined parser. Drives the rule write/read bus (wren/rden/addr/wdata) that the parser's conf port receives.
- Accepts one rule-programming command at a time from a host-side valid/ready stream. Encodes it into the parser rule address map and issues the write.
- Optionally reads the value back and checks it.
- Reports sticky error status and a write counter to the host.

Parameters:
- LAYER_W, 4, width of layer-select field (addr[15:12])
- KEY_NUM, 8, number of key-offset slots per layer; legal sel=3 idx range is 0..KEY_NUM-1
- GAP_CYCLES, 0, idle cycles forced after each write before the next command is accepted
- TIMEOUT, 16, max cycles to wait for readback data (verify builds only)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  loader can accept a command
- i_cmd_layer  in  LAYER_W  target parser layer
- i_cmd_sel  in  3  region: 0 rule, 1 type data/mask, 2 type offset, 3 key offset, 4 head shift, 5 meta shift
- i_cmd_idx  in  6  type id (sel 1/2) or keyField id (sel 3)
- i_cmd_wdata  in  32  rule data; for sel 3, bit16 = valid
- o_rule_wren  out  1  rule write strobe
- o_rule_rden  out  1  rule read strobe
- o_rule_addr  out  32  rule address
- o_rule_wdata  out  32  rule write data
- i_rule_rdata_valid  in  1  readback valid
- i_rule_rdata  in  32  readback data
- o_busy  out  1  state != IDLE
- o_wr_cnt  out  16  count of issued legal writes
- o_err  out  2  sticky error code: 0 none, 1 illegal, 2 mismatch, 3 timeout
- o_err_addr  out  32  address of the first error
- i_err_clr  in  1  clears o_err and o_err_addr

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high. While in reset all outputs are 0; state is IDLE, counters are 0.
- Address encoding: addr = {16'b0, layer, 1'b0, sel, 2'b0, idx}. Bits [10:8] = sel and [5:0] = idx, per the parser conf map. o_rule_addr and o_rule_wdata are registered and held until the next command.
- Handshake:
  - o_cmd_ready = (state == IDLE).
  - A command is accepted when valid && ready in cycle N.
  - o_rule_wren pulses exactly one cycle, in N+1.
- Legality check at accept:
  - sel > 5 is illegal.
  - sel in {0,4,5} with idx != 0 is illegal.
  - sel in {1,2} with idx > 15 is illegal.
  - sel = 3 with idx >= KEY_NUM is illegal.
  - An illegal command is consumed with no strobe. The error is logged with code 1 and the encoded address. State stays IDLE.
- FSM (states IDLE, WRITE, GAP, READ, WAIT):
  - IDLE → WRITE on a legal accept.
  - WRITE → READ in verify builds when sel != 0. Otherwise WRITE → GAP if GAP_CYCLES > 0, else → IDLE.
  - GAP counts GAP_CYCLES cycles, then → IDLE.
  - READ drives o_rule_rden for one cycle, then → WAIT.
  - WAIT → GAP/IDLE on i_rule_rdata_valid, or on timeout.
- o_wr_cnt increments in the WRITE cycle and wraps 0xFFFF → 0.
- Error latch:
  - Only the first error is captured while o_err != 0. Later errors are ignored.
  - When i_err_clr and a new error occur in the same cycle, the new error is captured.
- Throughput: one write per 2+GAP_CYCLES cycles, counted from accept to next accept.
- Reset mid-operation: any in-flight command is dropped with no further strobes. A late i_rule_rdata_valid is ignored in IDLE.
- i_rule_rdata_valid outside WAIT is ignored.

Optional Feature:
- Macro PARSER_RULE_VERIFY_EN.
- Defined:
  - READ/WAIT states exist. Writes with sel != 0 are read back from the same address.
  - Readback data != wdata → o_err = 2.
  - No i_rule_rdata_valid within TIMEOUT cycles of entering WAIT → o_err = 3, then leave WAIT.
  - o_rule_rden is functional.
- Undefined: o_rule_rden is tied 0, error codes 2 and 3 never occur, and READ/WAIT logic and the timeout counter are absent.

Decomposition:
- Add to parser_pkg:
  - rule_sel_e enum (RULE, TYPE_DATA, TYPE_OFFSET, KEY_OFFSET, HEAD_SHIFT, META_SHIFT)
  - rule_cmd_t struct (layer, sel, idx, wdata)
  - loader_err_e enum
  - Address-field position constants
  - A rule_addr_enc() function
- No sub-module. The FSM, gap/timeout counter and error latch live in a single module.

Test Plan:
- Layer 1, sel 1, idx 0, wdata 0x0000_08FF, GAP_CYCLES=0 → accept at N; wren=1 only at N+1; addr=0x0000_1100; wdata=0x0000_08FF; o_wr_cnt=1; ready again at N+2.
- Layer 1, sel 3, idx 2, wdata 0x0001_0007 → addr=0x0000_1302 with one wren pulse. With idx=8 and KEY_NUM=8 instead → no wren; o_err=1; o_err_addr=0x0000_1308.
- GAP_CYCLES=2, three back-to-back valid commands → wren pulses exactly 4 cycles apart; ready low during WRITE/GAP.
- Verify build: layer 2, sel 4, wdata 10; responder returns 9 two cycles after rden → o_err=2; o_err_addr=0x0000_2400. Pulse i_err_clr → o_err=0.
- Verify build: responder never returns data → after 16 cycles in WAIT, o_err=3 and state IDLE. A subsequent sel 0 command issues a write with no rden.
- Assert i_rst during WAIT → all outputs 0 immediately (asynchronous). A late rdata_valid after release leaves o_err=0 and o_wr_cnt=0.
